fetch_unit: RTL



---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch_buffer.sv | 81 ++++++++
 rtl/fetch_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  // PC loaded on reset and the last full word the 1 KiB ROM can return.
  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] MAX_ADDR = 32'd1020;

  // Default instruction buffer depth (power of two, at least 2).
  localparam int FETCH_DEPTH = 2;

  // One buffered instruction together with the byte address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  // Force an address onto a 4-byte boundary.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// In-order instruction FIFO between the ROM response and decode.
// Flush wins over push and pop; the head entry is read straight from storage.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_s  = (count_r == CNT_W'(DEPTH));
  assign empty_s = (count_r == {CNT_W{1'b0}});

  // Qualify push/pop: nothing moves on flush, pop needs data, push needs room
  // (a pop in the same cycle frees the slot being written).
  always_comb begin
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    if (flush) begin
      do_pop_s  = 1'b0;
      do_push_s = 1'b0;
    end else begin
      do_pop_s  = pop & ~empty_s;
      do_push_s = push & (~full_s | do_pop_s);
    end
  end

  // Storage, pointers and occupancy; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];
  assign empty = empty_s;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to the ROM, absorbs
// its one-cycle latency through a small buffer, and hands words to decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [INST_W-1:0] rom_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fault
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  fetch_state_t      state_r;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] inflight_pc_r;
  logic              inflight_r;
  logic              fault_r;

  logic [CNT_W-1:0]  buf_count_s;
  logic              buf_empty_s;
  fetch_entry_t      head_s;
  fetch_entry_t      push_data_s;
  logic              pop_s;
  logic              push_s;
  logic [OCC_W-1:0]  occ_s;
  logic [OCC_W-1:0]  limit_s;
  logic              room_s;
  logic              issue_s;
  logic              redirect_lsb_unused_s;

  // The low two redirect bits are dropped by word alignment.
  assign redirect_lsb_unused_s = ^redirect_pc[1:0];

  // Handshake decode and this cycle's issue decision. Buffered plus in-flight
  // words, less the one leaving now, must stay below DEPTH, so the buffer
  // can never overflow when the response lands.
  always_comb begin
    pop_s            = inst_valid & inst_ready;
    push_s           = inflight_r & ~redirect_valid;
    push_data_s.pc   = inflight_pc_r;
    push_data_s.inst = rom_data;
    occ_s            = OCC_W'(buf_count_s) + OCC_W'(inflight_r);
    limit_s          = OCC_W'(DEPTH) + OCC_W'(pop_s);
    room_s           = (occ_s < limit_s);
    if (!rst && !redirect_valid && (state_r == RUN) && room_s && (pc_r <= MAX_ADDR)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // PC, in-flight tracking and the RUN/FAULT state machine; redirect beats
  // everything and also clears a sticky fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= RUN;
      fault_r       <= 1'b0;
      pc_r          <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= {ADDR_W{1'b0}};
    end else if (redirect_valid) begin
      state_r    <= RUN;
      fault_r    <= 1'b0;
      pc_r       <= word_align(redirect_pc);
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        pc_r          <= pc_r + 32'd4;
        inflight_pc_r <= pc_r;
      end
      case (state_r)
        RUN: begin
          // Only an actual issue opportunity past the ROM end raises the fault.
          if (room_s && (pc_r > MAX_ADDR)) begin
            state_r <= FAULT;
            fault_r <= 1'b1;
          end
        end
        FAULT: begin
          state_r <= FAULT;
          fault_r <= 1'b1;
        end
        default: begin
          state_r <= FAULT;
          fault_r <= 1'b1;
        end
      endcase
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .count     (buf_count_s),
    .head      (head_s),
    .empty     (buf_empty_s)
  );

  assign rom_en     = issue_s;
  assign rom_addr   = pc_r;
  assign inst_valid = ~buf_empty_s;
  assign inst       = head_s.inst;
  assign inst_pc    = head_s.pc;
  assign fault      = fault_r;

endmodule
